dump_seq_ctrl: RTL and testbench
================================

# dump_seq_ctrl

Sequences the coil energy-dump phase of a pulse/echo cycle. It consumes the 12-bit elapsed count from the dump timer and drives that timer's `timer_start` enable. It produces `dump_on` (dump switch drive) for a programmed number of ON/GAP repetitions, then reports completion to the top-level acquisition state machine. Phase lengths are measured entirely on the external timer's count, so the block holds no wide timer of its own.

## Interface
- `LEN_W`, default 12: width of `count`, `on_len` and `gap_len`.
- `REP_W`, default 4: width of `rep_num`.

Ports:
- `clk_sys`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `state_start`  in  1  dump state active (level, from top FSM); also feeds the timer.
- `dump_start`  in  1  single-cycle request to start a dump sequence.
- `on_len`  in  LEN_W  ON phase length, in cycles.
- `gap_len`  in  LEN_W  GAP phase length, in cycles.
- `rep_num`  in  REP_W  number of ON+GAP repetitions.
- `count`  in  LEN_W  elapsed count from dump timer (0 on the cycle after its enable was low).
- `timer_start`  out  1  dump timer run enable.
- `dump_on`  out  1  dump switch drive.
- `dump_busy`  out  1  high whenever not IDLE.
- `dump_done`  out  1  one-cycle pulse on normal completion.
- `dump_abort`  out  1  one-cycle pulse on abort.

## Operation
- States: IDLE, CLR_ON, ON, CLR_GAP, GAP, DONE.
- Outputs are Moore decodes of the state register:
  - `timer_start` = ON | GAP
  - `dump_on` = ON
  - `dump_busy` = state != IDLE
  - `dump_done` = DONE
- IDLE:
  - `dump_start & state_start` → CLR_ON.
  - On that transition, latch `on_len`, `gap_len` and `rep_num` into shadow registers and clear the repetition counter `rep_cnt`.
- CLR_ON: one cycle with `timer_start`=0, so the timer is cleared → ON.
- ON: leave when `count == on_len_s - 1` → CLR_GAP.
- CLR_GAP: one cycle → GAP.
- GAP: leave when `count == gap_len_s - 1`.
  - If `rep_cnt == rep_num_s - 1` → DONE.
  - Otherwise increment `rep_cnt` → CLR_ON.
- DONE: one cycle → IDLE.
- Zero clamps: `on_len`, `gap_len` or `rep_num` of 0 is treated as 1 (clamped at latch time).
- Abort:
  - `state_start` low in any non-IDLE state → IDLE on the next edge.
  - `dump_abort` pulses for one cycle; no `dump_done`.
  - Abort has priority over every other transition, including the GAP→DONE transition.
- `dump_start` while busy is ignored. Config inputs may change while busy without effect (shadowed).
- `dump_start` together with `state_start`=0 in IDLE is ignored.

## Timing
- Reset values:
  - State: IDLE.
  - `rep_cnt`, shadows: 0.
  - `timer_start`, `dump_on`, `dump_busy`, `dump_done`, `dump_abort`: 0.
- `dump_start` sampled at edge t → CLR_ON during cycle t+1, and ON starts at t+2.
- `count` reads 0 in the first ON/GAP cycle and k in cycle k, so:
  - `dump_on` is high for exactly `on_len` consecutive cycles.
  - GAP lasts exactly `gap_len` cycles.
- Total from `dump_start` sample to `dump_done` high = 1 + `rep_num` × (`on_len` + `gap_len` + 2) cycles. `dump_done` is high during the last of those cycles.
- Equality compare only; `count` wrap is unreachable because the phase exits at `len-1` ≤ 4094.
- Reset asserted mid-sequence: all outputs drop asynchronously; no `dump_done` or `dump_abort` pulse.

## Configuration
- `DUMP_SEQ_MON_EN`
  - **Defined:** adds output `dump_on_total[15:0]`.
    - It counts clock cycles with `dump_on`=1 since the last accepted `dump_start`.
    - It clears in CLR_ON of the first repetition and saturates at 16'hFFFF.
    - It holds its value after DONE or abort, and resets to 0.
  - **Undefined:** the port and its logic are absent; all other behaviour is identical.

## Test plan
- Basic sequence: reset, then `state_start`=1, `on_len`=5, `gap_len`=3, `rep_num`=2, pulse `dump_start`.
  - `dump_on` gives two 5-cycle pulses separated by 5 cycles (CLR_GAP + GAP + CLR_ON).
  - `dump_done` arrives 21 cycles after the sample edge.
  - `timer_start` is low exactly in the CLR cycles.
- Zero clamp: `on_len`=0, `gap_len`=0, `rep_num`=0.
  - One 1-cycle `dump_on` pulse.
  - `dump_done` arrives 5 cycles after the sample edge.
- Abort: `on_len`=100, drop `state_start` at ON cycle 40.
  - `dump_on` low next cycle.
  - `dump_abort` pulses once, no `dump_done`, back in IDLE.
  - A new `dump_start` is accepted.
- Config change while busy: change `on_len` from 8 to 2 mid-sequence → the in-flight sequence keeps 8-cycle ON pulses. Pulse `dump_start` while busy → ignored.
- Async reset at GAP cycle 2 → all outputs 0 immediately, before the next clock edge.
- With `DUMP_SEQ_MON_EN`: `on_len`=7, `rep_num`=3 → `dump_on_total`=21 after done.

Source files
------------

// File: rtl/dump_seq_ctrl_if.sv
// Signal bundle between the dump sequencer and its surroundings (top FSM, dump timer).
// dump_on_total is present only when DUMP_SEQ_MON_EN is defined.
interface dump_seq_ctrl_if #(
  parameter int LEN_W = 12,
  parameter int REP_W = 4
);
  logic             state_start;
  logic             dump_start;
  logic [LEN_W-1:0] on_len;
  logic [LEN_W-1:0] gap_len;
  logic [REP_W-1:0] rep_num;
  logic [LEN_W-1:0] count;
  logic             timer_start;
  logic             dump_on;
  logic             dump_busy;
  logic             dump_done;
  logic             dump_abort;
`ifdef DUMP_SEQ_MON_EN
  logic [15:0]      dump_on_total;
`endif

  modport master (
    output state_start, dump_start, on_len, gap_len, rep_num, count,
    input  timer_start, dump_on, dump_busy, dump_done, dump_abort
`ifdef DUMP_SEQ_MON_EN
    , input dump_on_total
`endif
  );

  modport slave (
    input  state_start, dump_start, on_len, gap_len, rep_num, count,
    output timer_start, dump_on, dump_busy, dump_done, dump_abort
`ifdef DUMP_SEQ_MON_EN
    , output dump_on_total
`endif
  );
endinterface

// File: rtl/dump_seq_ctrl.sv
// Coil energy-dump sequencer: ON/GAP repetitions timed off the external dump timer count.
// Optional DUMP_SEQ_MON_EN adds a saturating count of dump_on cycles (dump_on_total).
module dump_seq_ctrl #(
  parameter int LEN_W = 12,
  parameter int REP_W = 4
) (
  input logic          clk_sys,
  input logic          rst,
  dump_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLR_ON,
    ON,
    CLR_GAP,
    GAP,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] on_len_s;
  logic [LEN_W-1:0] gap_len_s;
  logic [REP_W-1:0] rep_num_s;
  logic [REP_W-1:0] rep_cnt;
  logic             abort_q;
  logic             start_ok;
  logic             abort;
  logic             on_end;
  logic             gap_end;
  logic             last_rep;

  assign start_ok = (state == IDLE) && bus.dump_start && bus.state_start;
  assign abort    = (state != IDLE) && !bus.state_start;
  assign on_end   = bus.count == (on_len_s - LEN_W'(1));
  assign gap_end  = bus.count == (gap_len_s - LEN_W'(1));
  assign last_rep = rep_cnt == (rep_num_s - REP_W'(1));

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort is applied last so it overrides every phase exit, including GAP->DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = CLR_ON;
      CLR_ON:  state_nxt = ON;
      ON:      if (on_end) state_nxt = CLR_GAP;
      CLR_GAP: state_nxt = GAP;
      GAP:     if (gap_end) state_nxt = last_rep ? DONE : CLR_ON;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      on_len_s  <= '0;
      gap_len_s <= '0;
      rep_num_s <= '0;
      rep_cnt   <= '0;
    end else if (start_ok) begin
      on_len_s  <= (bus.on_len == '0) ? LEN_W'(1) : bus.on_len;
      gap_len_s <= (bus.gap_len == '0) ? LEN_W'(1) : bus.gap_len;
      rep_num_s <= (bus.rep_num == '0) ? REP_W'(1) : bus.rep_num;
      rep_cnt   <= '0;
    end else if ((state == GAP) && gap_end && !last_rep && !abort) begin
      rep_cnt <= rep_cnt + REP_W'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort;
    end
  end

  assign bus.timer_start = (state == ON) || (state == GAP);
  assign bus.dump_on     = (state == ON);
  assign bus.dump_busy   = (state != IDLE);
  assign bus.dump_done   = (state == DONE);
  assign bus.dump_abort  = abort_q;

`ifdef DUMP_SEQ_MON_EN
  logic [15:0] on_total;

  // Cleared only in the first repetition's CLR_ON, so the total spans the whole sequence.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      on_total <= '0;
    end else if ((state == CLR_ON) && (rep_cnt == '0)) begin
      on_total <= '0;
    end else if ((state == ON) && (on_total != 16'hFFFF)) begin
      on_total <= on_total + 16'd1;
    end
  end

  assign bus.dump_on_total = on_total;
`endif

endmodule

// File: tb/tb_dump_seq_ctrl.sv
// Self-checking bench for dump_seq_ctrl: models the dump timer and scores dump_on pulses,
// dump_done and dump_abort events against a queue of expected events.
module tb_dump_seq_ctrl;

  localparam int LEN_W = 12;
  localparam int REP_W = 4;

  localparam logic [1:0] EV_ON    = 2'd1;
  localparam logic [1:0] EV_DONE  = 2'd2;
  localparam logic [1:0] EV_ABORT = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] cyc;
    logic [31:0] len;
  } ev_t;

  logic clk_sys = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  exp_q[$];
  logic [4:0] outs;

  dump_seq_ctrl_if #(.LEN_W(LEN_W), .REP_W(REP_W)) bus();

  dump_seq_ctrl #(.LEN_W(LEN_W), .REP_W(REP_W)) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  assign outs = {bus.timer_start, bus.dump_on, bus.dump_busy, bus.dump_done, bus.dump_abort};

  // Dump timer model: count is 0 on the cycle after the enable was low.
  always @(posedge clk_sys or posedge rst) begin
    if (rst) bus.count <= '0;
    else if (bus.timer_start) bus.count <= bus.count + LEN_W'(1);
    else bus.count <= '0;
  end

  task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushEv(input logic [1:0] kind, input int c, input int len);
    ev_t e;
    e.kind = kind;
    e.cyc  = 32'(c);
    e.len  = 32'(len);
    exp_q.push_back(e);
  endtask

  task automatic matchEvent(input logic [1:0] kind, input int c, input int len);
    ev_t got;
    ev_t exp;
    got.kind = kind;
    got.cyc  = 32'(c);
    got.len  = 32'(len);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = '0;
    checkOutput($sformatf("event_kind%0d_cyc%0d", kind, c), {30'd0, got}, {30'd0, exp});
  endtask

  // Event monitor, sampling just after each active edge.
  int   on_start = 0;
  logic on_prev = 1'b0;
  always @(posedge clk_sys) begin
    #1;
    if (on_prev && !bus.dump_on) matchEvent(EV_ON, on_start, cyc - on_start);
    if (!on_prev && bus.dump_on) on_start = cyc;
    if (bus.dump_done) matchEvent(EV_DONE, cyc, 0);
    if (bus.dump_abort) matchEvent(EV_ABORT, cyc, 0);
    on_prev = bus.dump_on;
  end

  // Pulses dump_start for one cycle; t is the cycle in which CLR_ON is expected.
  task automatic applyStimulus(input int on, input int gap, input int rep, input bit push,
                               output int t);
    int on_c;
    int gap_c;
    int rep_c;
    int p;
    @(negedge clk_sys);
    bus.on_len     = LEN_W'(on);
    bus.gap_len    = LEN_W'(gap);
    bus.rep_num    = REP_W'(rep);
    bus.dump_start = 1'b1;
    t = cyc + 1;
    if (push) begin
      on_c  = (on == 0) ? 1 : on;
      gap_c = (gap == 0) ? 1 : gap;
      rep_c = (rep == 0) ? 1 : rep;
      p     = on_c + gap_c + 2;
      for (int r = 0; r < rep_c; r++) pushEv(EV_ON, t + 1 + r * p, on_c);
      pushEv(EV_DONE, t + rep_c * p, 0);
    end
    @(negedge clk_sys);
    bus.dump_start = 1'b0;
  endtask

  task automatic walkSchedule(input int t, input int on, input int gap, input int rep);
    int on_c;
    int gap_c;
    int rep_c;
    int p;
    int off;
    int o;
    logic [4:0] exp;
    on_c  = (on == 0) ? 1 : on;
    gap_c = (gap == 0) ? 1 : gap;
    rep_c = (rep == 0) ? 1 : rep;
    p     = on_c + gap_c + 2;
    for (int c = t; c <= t + rep_c * p; c++) begin
      off = c - t;
      o   = off % p;
      if (off == rep_c * p) exp = 5'b00110;
      else if ((o == 0) || (o == on_c + 1)) exp = 5'b00100;
      else if (o <= on_c) exp = 5'b11100;
      else exp = 5'b10100;
      checkOutput($sformatf("sched_off%0d", off), 96'(outs), 96'(exp));
      @(negedge clk_sys);
    end
    checkOutput("back_to_idle", 96'(outs), 96'(5'b00000));
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while (bus.dump_busy && (n < limit)) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput("idle_wait", 96'(bus.dump_busy), 96'(1'b0));
  endtask

  task automatic waitCycle(input int c);
    while (cyc < c) @(negedge clk_sys);
  endtask

  initial begin
    int t;
    bus.state_start = 1'b0;
    bus.dump_start  = 1'b0;
    bus.on_len      = '0;
    bus.gap_len     = '0;
    bus.rep_num     = '0;
    #1;
    checkOutput("reset_outs", 96'(outs), 96'(5'b00000));
`ifdef DUMP_SEQ_MON_EN
    checkOutput("reset_total", 96'(bus.dump_on_total), 96'(16'd0));
`endif
    repeat (2) @(negedge clk_sys);
    rst = 1'b0;
    @(negedge clk_sys);

    // dump_start without state_start is ignored
    applyStimulus(3, 3, 1, 1'b0, t);
    repeat (3) @(negedge clk_sys);
    checkOutput("start_without_state", 96'(outs), 96'(5'b00000));

    bus.state_start = 1'b1;
    @(negedge clk_sys);

    // basic sequence, cycle-by-cycle schedule
    applyStimulus(5, 3, 2, 1'b1, t);
    walkSchedule(t, 5, 3, 2);

    // zero clamp
    applyStimulus(0, 0, 0, 1'b1, t);
    walkSchedule(t, 0, 0, 0);

    // abort in ON cycle 40
    applyStimulus(100, 3, 1, 1'b0, t);
    pushEv(EV_ON, t + 1, 41);
    pushEv(EV_ABORT, t + 42, 0);
    waitCycle(t + 41);
    bus.state_start = 1'b0;
    @(negedge clk_sys);
    checkOutput("abort_outs", 96'(outs), 96'(5'b00001));
`ifdef DUMP_SEQ_MON_EN
    checkOutput("abort_total", 96'(bus.dump_on_total), 96'(16'd41));
`endif
    bus.state_start = 1'b1;
    @(negedge clk_sys);
    checkOutput("abort_single_pulse", 96'(outs), 96'(5'b00000));
    applyStimulus(2, 1, 1, 1'b1, t);
    waitIdle(50);

    // config change and dump_start while busy
    applyStimulus(8, 2, 2, 1'b1, t);
    repeat (3) @(negedge clk_sys);
    bus.on_len  = LEN_W'(2);
    bus.gap_len = LEN_W'(7);
    bus.rep_num = REP_W'(5);
    bus.dump_start = 1'b1;
    @(negedge clk_sys);
    bus.dump_start = 1'b0;
    waitIdle(100);

`ifdef DUMP_SEQ_MON_EN
    applyStimulus(7, 2, 3, 1'b1, t);
    waitIdle(100);
    checkOutput("on_total", 96'(bus.dump_on_total), 96'(16'd21));
`endif

    // async reset in GAP cycle 2
    applyStimulus(4, 4, 2, 1'b0, t);
    pushEv(EV_ON, t + 1, 4);
    waitCycle(t + 8);
    checkOutput("gap_before_reset", 96'(outs), 96'(5'b10100));
    rst = 1'b1;
    #1;
    checkOutput("async_reset_outs", 96'(outs), 96'(5'b00000));
`ifdef DUMP_SEQ_MON_EN
    checkOutput("async_reset_total", 96'(bus.dump_on_total), 96'(16'd0));
`endif
    @(negedge clk_sys);
    rst = 1'b0;
    repeat (3) @(negedge clk_sys);
    checkOutput("queue_empty", 96'(exp_q.size()), 96'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
